dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-master arbiter that shares the single data-memory port (word address, write data, 4-bit byte enables, read data) between the CPU data port (master 0) and a secondary master (master 1, e.g. DMA or debug loader).
- Round-robin arbitration with a bounded lock option for read-modify-write sequences.
- Accepted requests go through one register stage to the memory port. Read data returns on a fixed-latency valid strobe.
- Sits between the pipeline's MEM stage and the byte-enable memory model/bus.

Parameters:
- MAX_LOCK, 4: maximum consecutive cycles a locked master keeps the grant while the other master is requesting.
- TAG_W, 32: width of the per-request tag (instruction address), forwarded to the memory side for trace.

Ports:
- clk in 1: sole clock, rising edge.
- reset in 1: synchronous, active-low; reset==0 at a rising clk edge resets the block.
- m0_req in 1: master 0 request valid.
- m0_byteen in 4: byte enables; 4'b0000 means read.
- m0_addr in 32: byte address.
- m0_wdata in 32: write data, byte-lane aligned.
- m0_tag in TAG_W: request tag.
- m0_lock in 1: retain grant after this request.
- m0_gnt out 1: request accepted this cycle.
- m0_rvalid out 1: read data valid.
- m0_rdata out 32: read data.
- m1_req, m1_byteen, m1_addr, m1_wdata, m1_tag, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as master 0.
- mem_addr out 32: word-aligned address, addr & 32'hfffffffc.
- mem_wdata out 32: write data.
- mem_byteen out 4: write enables; 0 = no write.
- mem_tag out TAG_W: tag of the issued request.
- mem_rdata in 32: combinational read of word mem_addr.

Behaviour:
- Handshake: master holds req/byteen/addr/wdata/tag/lock stable until gnt. gnt is combinational from req and arbiter state. At most one gnt per cycle. Transfer occurs on any cycle with req && gnt.
- Arbitration state: last-grant pointer lg (reset 1, so master 0 wins the first tie), lock owner lo (none/0/1), lock counter lc (0..MAX_LOCK).
- Grant rules, in priority order:
  1. If lo==k, mk_req, and (other idle or lc<MAX_LOCK): grant k.
  2. Otherwise, if only one master requests: grant that master.
  3. Otherwise, if both request: grant ~lg.
- On each transfer: lg <= granted index.
  - Lock set (lo<=k) if mk_lock is asserted with the transfer; otherwise lo<=none.
  - lc increments while lo is held and the other master is requesting. lc clears when ownership changes or the lock is released.
  - When lc reaches MAX_LOCK the lock is broken: the other master gets the next grant, lo<=none.
- Issue stage (cycle N+1 after a transfer in cycle N):
  - mem_addr/mem_wdata/mem_byteen/mem_tag come from the registered request. The write commits at the clk edge ending N+1.
  - With no transfer in N: mem_byteen=0 and addr/wdata/tag hold their last values.
- Read return:
  - For a read (byteen==0) issued in N+1, mem_rdata is captured at the end of N+1.
  - mk_rvalid=1 and mk_rdata=captured value in N+2, for the owning master only, for one cycle.
  - Writes produce no rvalid.
- Throughput: one request per cycle, back-to-back, strictly in grant order. A read granted after a write to the same word returns the written data.
- Reset values: gnt 0 while reset==0. mem_addr 0, mem_wdata 0, mem_byteen 0, mem_tag 0. Both rvalid 0, both rdata 0. lg=1, lo=none, lc=0.
- Reset mid-operation: in-flight issue and return stages are discarded. No memory write occurs on the reset edge, and no rvalid follows.
- Misaligned byte enables are forwarded unchanged; they are not checked.
- rdata holds its value when rvalid is 0.

Test Plan:
- Reset then single m0 write (addr 0x10, byteen 4'b1111, wdata 0xdeadbeef): m0_gnt in cycle N. In N+1, mem_addr 0x10, mem_byteen 4'hf. A later m0 read of 0x10 gives m0_rvalid two cycles after gnt with rdata 0xdeadbeef.
- Both masters request reads continuously after reset: grants alternate m0, m1, m0, m1. The rvalid pulses alternate, and each rdata matches its own address.
- m1 sb (addr 0x23, byteen 4'b1000, wdata 0xab000000) back-to-back with m0 read of 0x20: write issued first. m0_rdata[31:24]=0xab, other bytes unchanged.
- m0 holds lock with req every cycle while m1 requests, MAX_LOCK=4: m0 granted 4 more cycles after the initial grant, then m1 granted. lo cleared and lc=0.
- m0 read granted, reset driven low the next cycle: mem_byteen 0, no m0_rvalid ever asserted. After release the first tie goes to m0.
- Idle after a write: mem_byteen returns to 0 the cycle after issue, and no spurious rvalid appears.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter for the data-memory port with bounded lock,
// a single issue register stage and fixed two-cycle read return.
module dm_arbiter #(
    parameter int MAX_LOCK = 4,
    parameter int TAG_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic [3:0]       m0_byteen,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [TAG_W-1:0] m0_tag,
    input  logic             m0_lock,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,
    input  logic             m1_req,
    input  logic [3:0]       m1_byteen,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [TAG_W-1:0] m1_tag,
    input  logic             m1_lock,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byteen,
    output logic [TAG_W-1:0] mem_tag,
    input  logic [31:0]      mem_rdata
);

    localparam int LC_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
    localparam logic [LC_W-1:0] LC_MAX = LC_W'(MAX_LOCK);

    typedef enum logic [1:0] {LO_NONE, LO_M0, LO_M1} lock_owner_e;

    logic              lg_q, lg_d;
    lock_owner_e       lo_q, lo_d;
    logic [LC_W-1:0]   lc_q, lc_d;

    logic              iss_vld_q, iss_vld_d;
    logic              iss_sel_q, iss_sel_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        byteen_q, byteen_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [31:0]       m0_rdata_q, m0_rdata_d;
    logic [31:0]       m1_rdata_q, m1_rdata_d;

    logic              gnt0, gnt1, xfer;
    logic              sel_lock, other_req, rd_fire;
    lock_owner_e       sel_lo;
    logic [3:0]        sel_byteen;
    logic [31:0]       sel_addr, sel_wdata;
    logic [TAG_W-1:0]  sel_tag;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (lo_q == LO_M0 && m0_req && (!m1_req || lc_q < LC_MAX)) begin
                gnt0 = 1'b1;
            end else if (lo_q == LO_M1 && m1_req && (!m0_req || lc_q < LC_MAX)) begin
                gnt1 = 1'b1;
            end else if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                gnt0 = lg_q;
                gnt1 = !lg_q;
            end
        end
    end

    assign xfer       = gnt0 | gnt1;
    assign sel_byteen = gnt1 ? m1_byteen : m0_byteen;
    assign sel_addr   = gnt1 ? m1_addr   : m0_addr;
    assign sel_wdata  = gnt1 ? m1_wdata  : m0_wdata;
    assign sel_tag    = gnt1 ? m1_tag    : m0_tag;
    assign sel_lock   = gnt1 ? m1_lock   : m0_lock;
    assign other_req  = gnt1 ? m0_req    : m1_req;
    assign sel_lo     = gnt1 ? LO_M1     : LO_M0;
    assign rd_fire    = iss_vld_q && (byteen_q == 4'b0000);

    always_comb begin
        lg_d        = lg_q;
        lo_d        = lo_q;
        lc_d        = lc_q;
        iss_vld_d   = xfer;
        iss_sel_d   = iss_sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byteen_d    = '0;
        tag_d       = tag_q;
        m0_rvalid_d = rd_fire && !iss_sel_q;
        m1_rvalid_d = rd_fire && iss_sel_q;
        m0_rdata_d  = m0_rvalid_d ? mem_rdata : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? mem_rdata : m1_rdata_q;
        if (xfer) begin
            lg_d      = gnt1;
            iss_sel_d = gnt1;
            addr_d    = {sel_addr[31:2], 2'b00};
            wdata_d   = sel_wdata;
            byteen_d  = sel_byteen;
            tag_d     = sel_tag;
            if (!sel_lock) begin
                lo_d = LO_NONE;
                lc_d = '0;
            end else if (lo_q != sel_lo) begin
                lo_d = sel_lo;
                lc_d = '0;
            end else if (other_req) begin
                // Reaching the limit drops ownership at once; lg already
                // points at the owner, so the waiting master wins next.
                if ((lc_q + LC_W'(1)) >= LC_MAX) begin
                    lo_d = LO_NONE;
                    lc_d = '0;
                end else begin
                    lc_d = lc_q + LC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lg_q        <= 1'b1;
            lo_q        <= LO_NONE;
            lc_q        <= '0;
            iss_vld_q   <= 1'b0;
            iss_sel_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byteen_q    <= '0;
            tag_q       <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            lg_q        <= lg_d;
            lo_q        <= lo_d;
            lc_q        <= lc_d;
            iss_vld_q   <= iss_vld_d;
            iss_sel_q   <= iss_sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byteen_q    <= byteen_d;
            tag_q       <= tag_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    assign m0_gnt     = gnt0;
    assign m1_gnt     = gnt1;
    assign m0_rvalid  = m0_rvalid_q;
    assign m1_rvalid  = m1_rvalid_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    // Gated by reset so a write sitting in the issue stage cannot commit on the reset edge.
    assign mem_byteen = reset ? byteen_q : '0;
    assign mem_tag    = tag_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: vector table for grants and issue,
// scoreboard for read returns against a shadow memory.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_lock, m0_gnt, m0_rvalid;
    logic [3:0]  m0_byteen;
    logic [31:0] m0_addr, m0_wdata, m0_tag, m0_rdata;
    logic        m1_req, m1_lock, m1_gnt, m1_rvalid;
    logic [3:0]  m1_byteen;
    logic [31:0] m1_addr, m1_wdata, m1_tag, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_tag, mem_rdata;
    logic [3:0]  mem_byteen;

    dm_arbiter #(.MAX_LOCK(4), .TAG_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_byteen(m0_byteen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_tag(m0_tag), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_byteen(m1_byteen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_tag(m1_tag), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
        .mem_tag(mem_tag), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic r0; logic [3:0] be0; logic [31:0] a0; logic [31:0] d0; logic l0;
        logic r1; logic [3:0] be1; logic [31:0] a1; logic [31:0] d1; logic l1;
        logic [1:0] g;
    } vec_t;

    typedef struct {
        int          master;
        logic [31:0] data;
        int          due;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    exp_t        sb[$];
    vec_t        tbl[$];
    logic [31:0] mem[64];
    logic [31:0] shadow[64];
    logic        prev_xfer = 1'b0;
    logic [31:0] pa, pwd, ptag;
    logic [3:0]  pb;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-enable memory model seen by the DUT.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_byteen[b]) mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    function automatic vec_t mk(input logic r0, input logic [3:0] be0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic l0,
                                input logic r1, input logic [3:0] be1, input logic [31:0] a1,
                                input logic [31:0] d1, input logic l1, input logic [1:0] g);
        vec_t v;
        v.r0 = r0; v.be0 = be0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
        v.r1 = r1; v.be1 = be1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
        v.g = g;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input bit track);
        int          k;
        logic [31:0] a, wd;
        logic [3:0]  be;
        @(posedge clk); #1;
        m0_req = v.r0; m0_byteen = v.be0; m0_addr = v.a0; m0_wdata = v.d0; m0_lock = v.l0;
        m0_tag = v.a0 ^ 32'hA000_0000;
        m1_req = v.r1; m1_byteen = v.be1; m1_addr = v.a1; m1_wdata = v.d1; m1_lock = v.l1;
        m1_tag = v.a1 ^ 32'hB000_0000;
        @(negedge clk);
        if (prev_xfer) begin
            chk("iss_addr", mem_addr, pa);
            chk("iss_byteen", 32'(mem_byteen), 32'(pb));
            chk("iss_wdata", mem_wdata, pwd);
            chk("iss_tag", mem_tag, ptag);
        end else begin
            chk("idle_byteen", 32'(mem_byteen), 32'd0);
        end
        chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, v.g});
        prev_xfer = 1'b0;
        if (track && v.g != 2'b00) begin
            k  = v.g[1] ? 1 : 0;
            a  = v.g[1] ? v.a1 : v.a0;
            be = v.g[1] ? v.be1 : v.be0;
            wd = v.g[1] ? v.d1 : v.d0;
            prev_xfer = 1'b1;
            pa = a & 32'hffff_fffc; pb = be; pwd = wd;
            ptag = a ^ (v.g[1] ? 32'hB000_0000 : 32'hA000_0000);
            if (be != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) shadow[a[7:2]][8*b +: 8] = wd[8*b +: 8];
            end else begin
                sb.push_back('{k, shadow[a[7:2]], cyc + 2});
            end
        end
    endtask

    task automatic do_reset(input int n, input bit full);
        @(posedge clk); #1;
        reset = 1'b0;
        m0_req = full; m1_req = full;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(posedge clk);
            @(negedge clk);
            chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
            chk("rst_byteen", 32'(mem_byteen), 32'd0);
            if (!full || i > 0)
                chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            if (full && i > 0) begin
                chk("rst_addr", mem_addr, 32'd0);
                chk("rst_wdata", mem_wdata, 32'd0);
                chk("rst_tag", mem_tag, 32'd0);
                chk("rst_rdata0", m0_rdata, 32'd0);
                chk("rst_rdata1", m1_rdata, 32'd0);
            end
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;
        prev_xfer = 1'b0;
    endtask

    // Read-return monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0 ? m0_rvalid : m1_rvalid) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_rvalid m%0d @cyc %0d: got rvalid 1, required 0", k, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rv_master", 32'(k), 32'(e.master));
                    chk("rv_cycle", 32'(cyc), 32'(e.due));
                    chk("rv_data", k == 0 ? m0_rdata : m1_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = init_word(i);
            shadow[i] = init_word(i);
        end
        reset = 1'b0;
        m0_req = 1'b1; m0_byteen = 0; m0_addr = 0; m0_wdata = 0; m0_tag = 0; m0_lock = 0;
        m1_req = 1'b1; m1_byteen = 0; m1_addr = 0; m1_wdata = 0; m1_tag = 0; m1_lock = 0;
        do_reset(3, 1'b1);

        // Alternating reads from both masters; m1 uses an unaligned address.
        tbl.push_back(mk(1, 0, 'h00, 0, 0, 1, 0, 'h41, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 'h04, 0, 0, 1, 0, 'h41, 0, 0, 2'b10));
        tbl.push_back(mk(1, 0, 'h04, 0, 0, 1, 0, 'h46, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 'h08, 0, 0, 1, 0, 'h46, 0, 0, 2'b10));
        tbl.push_back(idle()); tbl.push_back(idle());
        // Single write then read-back.
        tbl.push_back(mk(1, 4'hf, 'h10, 32'hdeadbeef, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(idle());
        tbl.push_back(mk(1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(idle()); tbl.push_back(idle());
        // Byte store from m1 wins the tie, then m0 reads the merged word.
        tbl.push_back(mk(1, 0, 'h20, 0, 0, 1, 4'b1000, 'h23, 32'hab000000, 0, 2'b10));
        tbl.push_back(mk(1, 0, 'h20, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(idle()); tbl.push_back(idle());
        // Lock: m0 keeps the grant for MAX_LOCK more cycles while m1 waits.
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 'h30, 0, 0, 2'b10));
        tbl.push_back(mk(1, 0, 'h00, 0, 1, 1, 0, 'h34, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 'h04, 0, 1, 1, 0, 'h34, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 'h08, 0, 1, 1, 0, 'h34, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 'h0c, 0, 1, 1, 0, 'h34, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 'h10, 0, 1, 1, 0, 'h34, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 'h14, 0, 1, 1, 0, 'h34, 0, 0, 2'b10));
        tbl.push_back(mk(1, 0, 'h14, 0, 1, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 'h18, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(idle()); tbl.push_back(idle());
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

        // Read granted, then reset: no rvalid may follow, and first tie goes to m0.
        step(mk(1, 0, 'h20, 0, 0, 0, 0, 0, 0, 0, 2'b01), 1'b0);
        do_reset(2, 1'b0);
        step(mk(1, 0, 'h24, 0, 0, 1, 0, 'h2c, 0, 0, 2'b01), 1'b1);
        step(mk(0, 0, 0, 0, 0, 1, 0, 'h2c, 0, 0, 2'b10), 1'b1);
        step(idle(), 1'b1); step(idle(), 1'b1);

        // Write granted, then reset during its issue cycle: the write must not land.
        step(mk(1, 4'hf, 'h28, 32'h12345678, 0, 0, 0, 0, 0, 0, 2'b01), 1'b0);
        do_reset(1, 1'b0);
        step(mk(1, 0, 'h28, 0, 0, 0, 0, 0, 0, 0, 2'b01), 1'b1);
        for (int i = 0; i < 4; i++) step(idle(), 1'b1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
